// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 block: register indices,
// exception codes, SR/Cause field positions and the EPC alignment helper.
package cp0_pkg;

   // mfc0/mtc0 register indices
   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_SR      = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;
   localparam logic [4:0] CP0_PRID    = 5'd15;

   // Exception codes recorded in Cause.ExcCode
   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   // SR field positions
   localparam int SR_IE        = 0;
   localparam int SR_EXL       = 1;
   localparam int SR_IM_SW_LO  = 8;
   localparam int SR_IM_HW_LO  = 10;

   // Cause field positions
   localparam int CAUSE_EXC_LO   = 2;
   localparam int CAUSE_IP_SW_LO = 8;
   localparam int CAUSE_IP_HW_LO = 10;
   localparam int CAUSE_BD       = 31;

   // Clears the two low bits of a return address when alignment is enabled
   function automatic logic [31:0] align_epc(input logic [31:0] addr, input logic en);
      return en ? {addr[31:2], 2'b00} : addr;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for cp0_ext. Count free-runs and wraps; a match of the
// post-update Count against Compare sets a sticky pending flag, and an mtc0 to
// Compare clears it unless a match happens in that same cycle.
module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wd,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        pending
);

   logic [31:0] count_next;
   logic [31:0] compare_next;

   // Next-state values: an mtc0 to Count beats the increment
   always_comb begin
      count_next   = count_we ? wd : count + 32'd1;
      compare_next = compare_we ? wd : compare;
   end

   // Timer registers; a match sets pending with priority over the Compare-write clear
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         compare <= '0;
         pending <= 1'b0;
      end else begin
         count   <= count_next;
         compare <= compare_next;
         if (count_next == compare_next)
            pending <= 1'b1;
         else if (compare_we)
            pending <= 1'b0;
      end
   end

endmodule

// File: rtl/cp0_ext.sv
// Coprocessor-0 block beside the M stage: SR, Cause, EPC, PRId and interrupt /
// exception arbitration feeding PC-select. Define CP0_TIMER_EN to build in the
// Count/Compare timer (registers 9/11, pending ORed into Cause.IP bit 15).
module cp0_ext
   import cp0_pkg::*;
#(
   parameter int          NUM_HWINT = 6,
   parameter logic [31:0] PRID_VAL  = 32'h17373488,
   parameter bit          EPC_ALIGN = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           RA,
   input  logic [4:0]           WA,
   input  logic [31:0]          WD,
   input  logic                 WE,
   input  logic [31:0]          PC,
   input  logic                 delay,
   input  logic [4:0]           ExcCode,
   input  logic [NUM_HWINT-1:0] HWInt,
   input  logic                 EXLClr,
   output logic                 IntReq,
   output logic [31:0]          EPC,
   output logic [31:0]          RD,
   output logic                 TimerIrq
);

`ifdef CP0_TIMER_EN
   localparam logic [5:0] TIMER_SLOT = 6'b100000;
`else
   localparam logic [5:0] TIMER_SLOT = 6'b000000;
`endif
   // Implemented IM/IP hardware slots; the timer always owns slot 5 when present
   localparam logic [6:0] HW_ONES = (7'd1 << NUM_HWINT) - 7'd1;
   localparam logic [5:0] HW_MASK = HW_ONES[5:0] | TIMER_SLOT;

   // Architectural state, kept as fields so unimplemented bits are constant 0
   logic        sr_ie, sr_exl;
   logic [1:0]  sr_im_sw;
   logic [5:0]  sr_im_hw;
   logic        cause_bd;
   logic [5:0]  cause_ip_hw;
   logic [1:0]  cause_ip_sw;
   logic [4:0]  cause_exc;
   logic [31:0] epc_q;

   logic [5:0]  hwint_ext;
   logic [5:0]  ip_hw_next;
   logic        interrupt, exception, entry, wr_en;
   logic [31:0] epc_entry;
   logic [31:0] sr_rd, cause_rd;
   logic [31:0] count, compare;
   logic        timer_pending;

`ifdef CP0_TIMER_EN
   cp0_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (wr_en && (WA == CP0_COUNT)),
      .compare_we (wr_en && (WA == CP0_COMPARE)),
      .wd         (WD),
      .count      (count),
      .compare    (compare),
      .pending    (timer_pending)
   );
`else
   assign count         = '0;
   assign compare       = '0;
   assign timer_pending = 1'b0;
`endif

   // Arbitration: new HWInt levels count in the same cycle; entry suppresses mtc0/eret
   always_comb begin
      hwint_ext                  = '0;
      hwint_ext[NUM_HWINT-1:0]   = HWInt;
      ip_hw_next                 = (hwint_ext | {timer_pending, 5'b00000}) & HW_MASK;
      interrupt = (|({ip_hw_next, cause_ip_sw} & {sr_im_hw, sr_im_sw})) & sr_ie & ~sr_exl;
      exception = (ExcCode != 5'd0) & ~sr_exl;
      entry     = (interrupt | exception) & ~reset;
      wr_en     = WE & ~entry;
      epc_entry = delay ? PC - 32'd4 : PC;
   end

   assign IntReq   = entry;
   assign EPC      = epc_q;
   assign TimerIrq = timer_pending;

   // State update in priority order: reset, entry, mtc0 write, then EXLClr on EXL only
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_ie       <= 1'b0;
         sr_exl      <= 1'b0;
         sr_im_sw    <= '0;
         sr_im_hw    <= '0;
         cause_bd    <= 1'b0;
         cause_ip_hw <= '0;
         cause_ip_sw <= '0;
         cause_exc   <= '0;
         epc_q       <= '0;
      end else begin
         cause_ip_hw <= ip_hw_next;
         if (entry) begin
            epc_q     <= align_epc(epc_entry, EPC_ALIGN);
            cause_bd  <= delay;
            cause_exc <= interrupt ? EXC_INT : ExcCode;
            sr_exl    <= 1'b1;
         end else begin
            if (WE) begin
               case (WA)
                  CP0_SR: begin
                     sr_ie    <= WD[SR_IE];
                     sr_exl   <= WD[SR_EXL];
                     sr_im_sw <= WD[SR_IM_SW_LO +: 2];
                     sr_im_hw <= WD[SR_IM_HW_LO +: 6] & HW_MASK;
                  end
                  CP0_CAUSE: cause_ip_sw <= WD[CAUSE_IP_SW_LO +: 2];
                  CP0_EPC:   epc_q       <= align_epc(WD, EPC_ALIGN);
                  default: ;
               endcase
            end
            if (EXLClr)
               sr_exl <= 1'b0;
         end
      end
   end

   // mfc0 read mux; shows pre-edge register values
   always_comb begin
      sr_rd                           = '0;
      sr_rd[SR_IE]                    = sr_ie;
      sr_rd[SR_EXL]                   = sr_exl;
      sr_rd[SR_IM_SW_LO +: 2]         = sr_im_sw;
      sr_rd[SR_IM_HW_LO +: 6]         = sr_im_hw;
      cause_rd                        = '0;
      cause_rd[CAUSE_BD]              = cause_bd;
      cause_rd[CAUSE_IP_HW_LO +: 6]   = cause_ip_hw;
      cause_rd[CAUSE_IP_SW_LO +: 2]   = cause_ip_sw;
      cause_rd[CAUSE_EXC_LO +: 5]     = cause_exc;
      case (RA)
         CP0_SR:      RD = sr_rd;
         CP0_CAUSE:   RD = cause_rd;
         CP0_EPC:     RD = epc_q;
         CP0_PRID:    RD = PRID_VAL;
         CP0_COUNT:   RD = count;
         CP0_COMPARE: RD = compare;
         default:     RD = '0;
      endcase
   end

endmodule
